muldiv_unit: RTL and testbench

Iterative RV32M/RV64M multiply/divide unit that sits beside the ALU in the EX stage of the 5-stage pipeline. It accepts one operation at a time and holds the pipeline through `busy`, which is ORed into the hazard Stall path. The data width and the number of bits retired per cycle are parameters. This gives the core the M extension without lengthening the critical path.

---
 rtl/muldiv_pkg.sv | 41 ++++
 rtl/muldiv_if.sv | 30 +++
 rtl/muldiv_step.sv | 39 +++
 rtl/muldiv_unit.sv | 189 ++++++++++++++++++
 tb/tb_muldiv_unit.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// -----------------------------------------------------------------------------
// muldiv_pkg
// Shared types for the iterative multiply/divide unit: funct3 operation codes,
// the control FSM state encoding and small operation-class helpers.
// -----------------------------------------------------------------------------
package muldiv_pkg;

   // funct3 encoding of the RV32M/RV64M operations
   typedef enum logic [2:0] {
      MD_MUL    = 3'd0,
      MD_MULH   = 3'd1,
      MD_MULHSU = 3'd2,
      MD_MULHU  = 3'd3,
      MD_DIV    = 3'd4,
      MD_DIVU   = 3'd5,
      MD_REM    = 3'd6,
      MD_REMU   = 3'd7
   } md_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CALC    = 2'd1,
      FIXUP   = 2'd2,
      SPECIAL = 2'd3
   } md_state_e;

   function automatic logic is_div(input md_op_e op);
      return op inside {MD_DIV, MD_DIVU, MD_REM, MD_REMU};
   endfunction

   // rs1 is treated as signed
   function automatic logic a_signed(input md_op_e op);
      return op inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM};
   endfunction

   // rs2 is treated as signed
   function automatic logic b_signed(input md_op_e op);
      return op inside {MD_MUL, MD_MULH, MD_DIV, MD_REM};
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// -----------------------------------------------------------------------------
// muldiv_if
// Request/response bundle between the EX stage and the multiply/divide unit.
//   master (EX stage): drives start, op, a, b, rd_in, flush
//   slave  (unit)    : drives busy, done, result, rd_out
// -----------------------------------------------------------------------------
interface muldiv_if #(
   parameter int XLEN = 32
) ();
   logic            start;
   logic [2:0]      op;
   logic [XLEN-1:0] a;
   logic [XLEN-1:0] b;
   logic [4:0]      rd_in;
   logic            flush;
   logic            busy;
   logic            done;
   logic [XLEN-1:0] result;
   logic [4:0]      rd_out;

   modport master (
      output start, op, a, b, rd_in, flush,
      input  busy, done, result, rd_out
   );

   modport slave (
      input  start, op, a, b, rd_in, flush,
      output busy, done, result, rd_out
   );
endinterface

// File: rtl/muldiv_step.sv
// -----------------------------------------------------------------------------
// muldiv_step
// One combinational iteration on the 2*XLEN accumulator.
//   is_div = 0 : shift-add multiply step. acc = {partial product, multiplier};
//                add opnd (multiplicand) into the high half when acc[0]=1,
//                then shift the whole accumulator right by one.
//   is_div = 1 : restoring divide step. acc = {remainder, dividend/quotient};
//                shift left by one, trial-subtract opnd (divisor) from the
//                remainder and shift the quotient bit into acc[0].
// Ports: is_div, acc_i (2*XLEN), opnd (XLEN) in; acc_o (2*XLEN) out.
// -----------------------------------------------------------------------------
module muldiv_step #(
   parameter int XLEN = 32
) (
   input  logic                is_div,
   input  logic [2*XLEN-1:0]   acc_i,
   input  logic [XLEN-1:0]     opnd,
   output logic [2*XLEN-1:0]   acc_o
);

   logic [XLEN:0] sum;
   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   always_comb begin
      sum   = {1'b0, acc_i[2*XLEN-1:XLEN]} + (acc_i[0] ? {1'b0, opnd} : '0);
      // remainder shifted left with the next dividend bit; fits XLEN+1 bits
      // because the running remainder is always below the divisor
      trial = acc_i[2*XLEN-1:XLEN-1];
      diff  = trial - {1'b0, opnd};
      acc_o = {sum, acc_i[XLEN-1:1]};
      if (is_div) begin
         // a set top bit means the subtraction borrowed: restore
         if (diff[XLEN]) acc_o = {trial[XLEN-1:0], acc_i[XLEN-2:0], 1'b0};
         else            acc_o = {diff[XLEN-1:0], acc_i[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/muldiv_unit.sv
// -----------------------------------------------------------------------------
// muldiv_unit
// Iterative RV32M/RV64M multiply/divide unit for the EX stage. One operation
// at a time; busy stalls the pipeline while an operation is in flight.
// Works on operand magnitudes and fixes signs at the end; divide-by-zero and
// signed overflow bypass the iteration and complete one cycle after accept.
// Ports:
//   clk, reset   : rising-edge clock, synchronous active-high reset
//   bus (slave)  : start/op/a/b/rd_in/flush requests in,
//                  busy/done/result/rd_out out (result/rd_out held)
// Parameters: XLEN (32/64), BITS_PER_CYCLE (1/2/4) steps per CALC cycle.
// -----------------------------------------------------------------------------
module muldiv_unit
   import muldiv_pkg::*;
#(
   parameter int XLEN           = 32,
   parameter int BITS_PER_CYCLE = 1
) (
   input  logic     clk,
   input  logic     reset,
   muldiv_if.slave  bus
);

   localparam int N     = XLEN / BITS_PER_CYCLE;
   localparam int CNT_W = $clog2(N + 1);
   localparam int W2    = 2 * XLEN;
   localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

   if (!((XLEN == 32 || XLEN == 64) &&
         (BITS_PER_CYCLE == 1 || BITS_PER_CYCLE == 2 || BITS_PER_CYCLE == 4)))
   begin : g_param_check
      $error("muldiv_unit: unsupported XLEN/BITS_PER_CYCLE");
   end

   md_state_e        state_q, state_d;
   md_op_e           op_q, op_d;
   logic [W2-1:0]    acc_q, acc_d;
   logic [XLEN-1:0]  opnd_q, opnd_d;     // |b|: multiplicand or divisor
   logic             neg_q, neg_d;       // product / quotient negate
   logic             sa_q, sa_d;         // dividend sign -> remainder sign
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [4:0]       rd_q, rd_d;
   logic [4:0]       rd_out_q, rd_out_d;
   logic [XLEN-1:0]  result_q, result_d;
   logic             done_q, done_d;

   // ---------------- request decode ----------------
   md_op_e          in_op;
   logic            in_sa, in_sb, div0, ovf, special;
   logic [XLEN-1:0] a_mag, b_mag, spec_res;

   assign in_op   = md_op_e'(bus.op);
   assign in_sa   = a_signed(in_op) & bus.a[XLEN-1];
   assign in_sb   = b_signed(in_op) & bus.b[XLEN-1];
   assign a_mag   = in_sa ? -bus.a : bus.a;
   assign b_mag   = in_sb ? -bus.b : bus.b;
   assign div0    = is_div(in_op) && (bus.b == '0);
   assign ovf     = (in_op inside {MD_DIV, MD_REM}) && (bus.a == MIN_NEG) && (bus.b == '1);
   assign special = div0 | ovf;

   always_comb begin
      spec_res = '0;                                // REM overflow
      if (div0)                spec_res = (in_op inside {MD_DIV, MD_DIVU}) ? '1 : bus.a;
      else if (in_op == MD_DIV) spec_res = bus.a;   // DIV overflow
   end

   // ---------------- iteration chain ----------------
   logic [BITS_PER_CYCLE:0][W2-1:0] chain;
   logic                            op_is_div;

   assign chain[0]  = acc_q;
   assign op_is_div = is_div(op_q);

   for (genvar gi = 0; gi < BITS_PER_CYCLE; gi++) begin : g_step
      muldiv_step #(.XLEN(XLEN)) u_step (
         .is_div (op_is_div),
         .acc_i  (chain[gi]),
         .opnd   (opnd_q),
         .acc_o  (chain[gi+1])
      );
   end

   // ---------------- sign fixup / half select ----------------
   logic [W2-1:0]   prod;
   logic [XLEN-1:0] fix_res;

   always_comb begin
      prod    = neg_q ? -acc_q : acc_q;
      fix_res = prod[W2-1:XLEN];
      case (op_q)
         MD_MUL:          fix_res = prod[XLEN-1:0];
         MD_DIV, MD_DIVU: fix_res = neg_q ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
         MD_REM, MD_REMU: fix_res = sa_q ? -acc_q[W2-1:XLEN] : acc_q[W2-1:XLEN];
         default:         fix_res = prod[W2-1:XLEN];
      endcase
   end

   // ---------------- FSM next state ----------------
   always_comb begin
      state_d  = state_q;
      op_d     = op_q;
      acc_d    = acc_q;
      opnd_d   = opnd_q;
      neg_d    = neg_q;
      sa_d     = sa_q;
      cnt_d    = cnt_q;
      rd_d     = rd_q;
      rd_out_d = rd_out_q;
      result_d = result_q;
      done_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.start && !bus.flush) begin
               op_d    = in_op;
               opnd_d  = b_mag;
               neg_d   = in_sa ^ in_sb;
               sa_d    = in_sa;
               rd_d    = bus.rd_in;
               cnt_d   = '0;
               // multiplier and dividend both start in the low half;
               // special cases park their answer there instead
               acc_d   = {{XLEN{1'b0}}, (special ? spec_res : a_mag)};
               state_d = special ? SPECIAL : CALC;
            end
         end
         CALC: begin
            acc_d = chain[BITS_PER_CYCLE];
            cnt_d = cnt_q + CNT_W'(1);
            if (cnt_q == CNT_W'(N - 1)) state_d = FIXUP;
         end
         FIXUP: begin
            result_d = fix_res;
            rd_out_d = rd_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         SPECIAL: begin
            result_d = acc_q[XLEN-1:0];
            rd_out_d = rd_q;
            done_d   = 1'b1;
            state_d  = IDLE;
         end
         default: state_d = IDLE;
      endcase

      // abort anything in flight without disturbing the visible result
      if (bus.flush && state_q != IDLE) begin
         state_d  = IDLE;
         result_d = result_q;
         rd_out_d = rd_out_q;
         done_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= IDLE;
         op_q     <= MD_MUL;
         acc_q    <= '0;
         opnd_q   <= '0;
         neg_q    <= 1'b0;
         sa_q     <= 1'b0;
         cnt_q    <= '0;
         rd_q     <= '0;
         rd_out_q <= '0;
         result_q <= '0;
         done_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         op_q     <= op_d;
         acc_q    <= acc_d;
         opnd_q   <= opnd_d;
         neg_q    <= neg_d;
         sa_q     <= sa_d;
         cnt_q    <= cnt_d;
         rd_q     <= rd_d;
         rd_out_q <= rd_out_d;
         result_q <= result_d;
         done_q   <= done_d;
      end
   end

   assign bus.busy   = (state_q != IDLE);
   assign bus.done   = done_q;
   assign bus.result = result_q;
   assign bus.rd_out = rd_out_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// -----------------------------------------------------------------------------
// tb_muldiv_unit
// Two instances: XLEN=32/1 bit per cycle and XLEN=64/4 bits per cycle.
// Each request pushes its expected result, tag and completion cycle into a
// queue; a monitor per instance pops and compares on every done pulse.
// -----------------------------------------------------------------------------
module tb_muldiv_unit;
   import muldiv_pkg::*;

   localparam int N32 = 32;
   localparam int N64 = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   muldiv_if #(.XLEN(32)) m32 ();
   muldiv_if #(.XLEN(64)) m64 ();

   muldiv_unit #(.XLEN(32), .BITS_PER_CYCLE(1)) u32 (.clk(clk), .reset(reset), .bus(m32));
   muldiv_unit #(.XLEN(64), .BITS_PER_CYCLE(4)) u64 (.clk(clk), .reset(reset), .bus(m64));

   typedef struct {
      logic [63:0] res;
      logic [4:0]  rd;
      int          due;
   } exp_t;

   exp_t        q32[$];
   exp_t        q64[$];
   exp_t        e32, e64;
   logic [63:0] last32 = '0;
   logic [4:0]  lastrd32 = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain wide signed arithmetic following the RISC-V M rules.
   function automatic logic [63:0] model(input int xl, input logic [2:0] op,
                                         input logic [63:0] a_in, input logic [63:0] b_in);
      logic [63:0]        mask, a, b;
      logic signed [129:0] ua, ub, sa, sb, r, minv;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      a    = a_in & mask;
      b    = b_in & mask;
      ua   = $signed({66'b0, a});
      ub   = $signed({66'b0, b});
      sa   = a[xl-1] ? ua - (130'sd1 <<< xl) : ua;
      sb   = b[xl-1] ? ub - (130'sd1 <<< xl) : ub;
      minv = -(130'sd1 <<< (xl - 1));
      case (op)
         3'd0: r = sa * sb;
         3'd1: r = (sa * sb) >>> xl;
         3'd2: r = (sa * ub) >>> xl;
         3'd3: r = (ua * ub) >>> xl;
         3'd4: r = (b == 0) ? -130'sd1 : (sa == minv && sb == -1) ? sa : sa / sb;
         3'd5: r = (b == 0) ? -130'sd1 : ua / ub;
         3'd6: r = (b == 0) ? sa : (sa == minv && sb == -1) ? 130'sd0 : sa % sb;
         default: r = (b == 0) ? ua : ua % ub;
      endcase
      return r[63:0] & mask;
   endfunction

   function automatic bit is_special(input int xl, input logic [2:0] op,
                                     input logic [63:0] a, input logic [63:0] b);
      logic [63:0] mask, minv;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      minv = 64'd1 << (xl - 1);
      if (op < 3'd4) return 1'b0;
      if ((b & mask) == 0) return 1'b1;
      return (op == 3'd4 || op == 3'd6) && ((a & mask) == minv) && ((b & mask) == mask);
   endfunction

   function automatic logic [63:0] pick(input int xl);
      logic [63:0] mask, v;
      mask = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
      case ($urandom_range(0, 7))
         0:       v = 64'd0;
         1:       v = mask;
         2:       v = 64'd1 << (xl - 1);
         3:       v = 64'($urandom_range(0, 20));
         default: v = {$urandom, $urandom};
      endcase
      return v & mask;
   endfunction

   // Waits for an idle cycle, presents one request for one edge.
   task automatic issue(input bit w64, input logic [2:0] op, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd, input bit track,
                        input logic [63:0] exp_v);
      int   n = 0;
      int   lat;
      exp_t e;
      @(negedge clk);
      while ((w64 ? m64.busy : m32.busy) && n < 300) begin
         @(negedge clk);
         n++;
      end
      if (n >= 300) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: busy still %0d after %0d cycles", 1, n);
         return;
      end
      lat   = is_special(w64 ? 64 : 32, op, a, b) ? 1 : (w64 ? N64 : N32) + 1;
      e.res = exp_v;
      e.rd  = rd;
      e.due = cyc + 1 + lat;
      if (w64) begin
         m64.start = 1'b1; m64.op = op; m64.a = a; m64.b = b; m64.rd_in = rd;
         if (track) q64.push_back(e);
      end else begin
         m32.start = 1'b1; m32.op = op; m32.a = a[31:0]; m32.b = b[31:0]; m32.rd_in = rd;
         if (track) begin
            q32.push_back(e);
            last32   = exp_v;
            lastrd32 = rd;
         end
      end
      @(posedge clk);
      #1;
      m32.start = 1'b0;
      m64.start = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!reset && m32.done) begin
         if (q32.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done32: got unexpected done at cycle %0d, expected none", cyc);
         end else begin
            e32 = q32.pop_front();
            chk("result32", {32'b0, m32.result}, e32.res);
            chk("rd32", 64'(m32.rd_out), 64'(e32.rd));
            chk("latency32", 64'(cyc), 64'(e32.due));
         end
      end
   end

   always @(negedge clk) begin
      if (!reset && m64.done) begin
         if (q64.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL done64: got unexpected done at cycle %0d, expected none", cyc);
         end else begin
            e64 = q64.pop_front();
            chk("result64", m64.result, e64.res);
            chk("rd64", 64'(m64.rd_out), 64'(e64.rd));
            chk("latency64", 64'(cyc), 64'(e64.due));
         end
      end
   end

   initial begin
      logic [2:0]  op;
      logic [63:0] a, b;
      int          n;
      m32.start = 0; m32.op = 0; m32.a = 0; m32.b = 0; m32.rd_in = 0; m32.flush = 0;
      m64.start = 0; m64.op = 0; m64.a = 0; m64.b = 0; m64.rd_in = 0; m64.flush = 0;
      repeat (3) @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("rst_busy32", 64'(m32.busy), 0);
      chk("rst_done32", 64'(m32.done), 0);
      chk("rst_result32", 64'(m32.result), 0);
      chk("rst_rd32", 64'(m32.rd_out), 0);
      chk("rst_busy64", 64'(m64.busy), 0);
      chk("rst_result64", m64.result, 0);

      // directed cases with hand-computed answers
      issue(0, MD_MUL,   64'd7,          64'hFFFF_FFFD, 5'd1,  1, 64'hFFFF_FFEB);
      issue(0, MD_MULH,  64'h8000_0000,  64'h8000_0000, 5'd2,  1, 64'h4000_0000);
      issue(0, MD_MULHU, 64'hFFFF_FFFF,  64'hFFFF_FFFF, 5'd3,  1, 64'hFFFF_FFFE);
      issue(0, MD_DIV,   64'hFFFF_FFF9,  64'd2,         5'd4,  1, 64'hFFFF_FFFD);
      issue(0, MD_REM,   64'hFFFF_FFF9,  64'd2,         5'd5,  1, 64'hFFFF_FFFF);
      issue(0, MD_DIVU,  64'd100,        64'd7,         5'd6,  1, 64'd14);
      issue(0, MD_REMU,  64'd100,        64'd7,         5'd7,  1, 64'd2);
      issue(0, MD_DIVU,  64'd100,        64'd0,         5'd8,  1, 64'hFFFF_FFFF);
      issue(0, MD_REMU,  64'd100,        64'd0,         5'd9,  1, 64'd100);
      issue(0, MD_DIV,   64'h8000_0000,  64'hFFFF_FFFF, 5'd10, 1, 64'h8000_0000);
      issue(0, MD_REM,   64'h8000_0000,  64'hFFFF_FFFF, 5'd11, 1, 64'd0);

      // start while busy is ignored: only one done for the MULHSU
      a = pick(32); b = pick(32);
      issue(0, MD_MULHSU, a, b, 5'd12, 1, model(32, MD_MULHSU, a, b));
      repeat (3) @(negedge clk);
      m32.start = 1'b1; m32.op = MD_MUL; m32.a = 32'd5; m32.b = 32'd5; m32.rd_in = 5'd13;
      repeat (2) @(negedge clk);
      m32.start = 1'b0;

      // flush mid-divide: no done, result and tag keep their old values
      issue(0, MD_DIV, 64'd1000, 64'd3, 5'd14, 0, 64'd0);
      repeat (10) @(negedge clk);
      m32.flush = 1'b1;
      @(posedge clk);
      #1 m32.flush = 1'b0;
      @(negedge clk);
      chk("flush_busy", 64'(m32.busy), 0);
      chk("flush_result", 64'(m32.result), last32);
      chk("flush_rd", 64'(m32.rd_out), 64'(lastrd32));
      repeat (40) @(negedge clk);

      // flush together with start in an idle cycle blocks the start
      m32.start = 1'b1; m32.flush = 1'b1; m32.op = MD_MUL; m32.a = 32'd2; m32.b = 32'd3;
      @(posedge clk);
      #1 begin m32.start = 1'b0; m32.flush = 1'b0; end
      @(negedge clk);
      chk("flush_start_busy", 64'(m32.busy), 0);
      repeat (40) @(negedge clk);

      // reset mid-CALC aborts without a done pulse
      issue(0, MD_DIVU, 64'd100, 64'd7, 5'd15, 0, 64'd0);
      repeat (5) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      chk("midrst_busy", 64'(m32.busy), 0);
      chk("midrst_done", 64'(m32.done), 0);
      chk("midrst_result", 64'(m32.result), 0);
      chk("midrst_rd", 64'(m32.rd_out), 0);
      issue(0, MD_MUL, 64'd2, 64'd3, 5'd16, 1, 64'd6);

      // random 32-bit traffic
      repeat (40) begin
         op = 3'($urandom_range(0, 7));
         a  = pick(32);
         b  = pick(32);
         issue(0, op, a, b, 5'($urandom_range(0, 31)), 1, model(32, op, a, b));
      end

      // 64-bit, 4 bits/cycle: back-to-back starts in the done cycle
      issue(1, MD_MULHU, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd5, 1,
            64'hFFFF_FFFF_FFFF_FFFE);
      issue(1, MD_DIVU, 64'd1000, 64'd7, 5'd9, 1, 64'd142);
      issue(1, MD_DIV, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd3, 1,
            64'h8000_0000_0000_0000);
      repeat (20) begin
         op = 3'($urandom_range(0, 7));
         a  = pick(64);
         b  = pick(64);
         issue(1, op, a, b, 5'($urandom_range(0, 31)), 1, model(64, op, a, b));
      end

      n = 0;
      while ((q32.size() != 0 || q64.size() != 0) && n < 500) begin
         @(negedge clk);
         n++;
      end
      chk("drain32", 64'(q32.size()), 0);
      chk("drain64", 64'(q64.size()), 0);
      repeat (3) @(negedge clk);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
